axi_lite_master: RTL and testbench
==================================

Name: axi_lite_master

Overview:
- Single-outstanding AXI4-Lite initiator that turns a simple command/response interface into one AXI4-Lite read or write transaction.
- Drives the register-bank slaves in this codebase, e.g. the reg1/reg2 controller at 0x00/0x04, from test sequencers or local control FSMs.
- No BRESP/RRESP channels, matching our slaves. Completion is reported on the response port, with a timeout flag.

Parameters:
AXI_ADDRESS_WIDTH, 5, width of awaddr/araddr/cmd_addr
AXI_DATA_WIDTH, 32, width of wdata/rdata
TIMEOUT_CYCLES, 255, cycles allowed per transaction before abort; 0 disables the timeout

Ports:
aclk  in  1  clock; all logic on rising edge
aresetn  in  1  reset, asynchronous, active-low
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  AXI_ADDRESS_WIDTH  byte address
cmd_wdata  in  AXI_DATA_WIDTH  write data, ignored for reads
rsp_valid  out  1  transaction complete
rsp_ready  in  1  response consumed when rsp_valid & rsp_ready
rsp_rdata  out  AXI_DATA_WIDTH  read data; 0 for writes and timeouts
rsp_timeout  out  1  transaction aborted by timeout
maxi_awaddr  out  AXI_ADDRESS_WIDTH  write address
maxi_awvalid  out  1
maxi_awready  in  1
maxi_wdata  out  AXI_DATA_WIDTH
maxi_wvalid  out  1
maxi_wready  in  1
maxi_bvalid  in  1
maxi_bready  out  1
maxi_araddr  out  AXI_ADDRESS_WIDTH
maxi_arvalid  out  1
maxi_arready  in  1
maxi_rdata  in  AXI_DATA_WIDTH
maxi_rvalid  in  1
maxi_rready  out  1

Behaviour:
- Reset values:
  - State IDLE; cmd_ready=1.
  - All maxi_*valid, maxi_bready, maxi_rready, rsp_valid and rsp_timeout are 0.
  - All address/data registers and rsp_rdata are 0.
- All outputs are registered, except cmd_ready = (state==IDLE).
- States: IDLE, WADDR_DATA, WRESP, RADDR, RDATA, RESP.
- IDLE:
  - On cmd_valid, latch addr and wdata.
  - Write → WADDR_DATA, with awvalid and wvalid both 1 on the next cycle.
  - Read → RADDR, with arvalid 1 on the next cycle.
- WADDR_DATA:
  - awvalid and wvalid each drop the cycle after their own handshake (valid & ready sampled at the edge); the two are tracked independently, in either order or simultaneously.
  - When both handshakes are done → WRESP, with bready=1.
- WRESP: on bvalid & bready → RESP; bready drops; rsp_rdata=0.
- RADDR: on arvalid & arready → RDATA; arvalid drops; rready=1.
- RDATA: on rvalid & rready, capture maxi_rdata into rsp_rdata → RESP; rready drops.
- RESP:
  - rsp_valid=1 and held, with rsp_rdata and rsp_timeout stable, until rsp_ready.
  - Then → IDLE, with rsp_valid and rsp_timeout cleared.
- AXI rules:
  - Once asserted, a valid is held with stable addr/data until its handshake; it is never withdrawn except on timeout or reset.
  - Valids never depend combinationally on readies.
- Latency: command accept at edge N → AXI valid high in cycle N+1. Zero-wait slave: read rsp_valid at N+3; write rsp_valid at N+3 + the slave's bvalid delay.
- Timeout counter:
  - Width clog2(TIMEOUT_CYCLES+1). Clears on every state change, increments in the four AXI states, saturates.
  - On reaching TIMEOUT_CYCLES, drop all maxi valids/readies → RESP with rsp_timeout=1 and rsp_rdata=0.
  - A handshake completing in the same cycle as the terminal count wins: normal completion, no timeout.
- No new command is accepted until the previous response is consumed. cmd_valid outside IDLE is ignored.
- Reset mid-transaction: everything returns to reset values immediately, asynchronously. No response is issued for the aborted command.

Decomposition:
- Shared package axi_lite_pkg:
  - master state enum and default AXI_ADDRESS_WIDTH/AXI_DATA_WIDTH constants, shared with the slave
  - register map constants REG1_ADDR=0x00 and REG2_ADDR=0x04
- One sub-module, axi_lite_timeout_cnt: saturating counter with clear/enable/terminal-count outputs, parameterised by TIMEOUT_CYCLES.

Test Plan:
- Write 0x00←0xDEADBEEF to the sister slave, then read 0x00 → write rsp_valid with rsp_timeout=0; read rsp_rdata=0xDEADBEEF; slave reg1=0xDEADBEEF.
- Write 0x04←0x12345678 with a stub slave giving wready 3 cycles before awready → wvalid drops first, awvalid held; exactly one response; reg2 read=0x12345678.
- TIMEOUT_CYCLES=16, bvalid never asserted → rsp_valid with rsp_timeout=1 and rsp_rdata=0, 16 cycles after WRESP entry; bready low afterwards.
- Read with rsp_ready held low 10 cycles → rsp_valid and rsp_rdata stable for all 10; cmd_ready=0 throughout; back-to-back command accepted the cycle after rsp_ready.
- aresetn low while arvalid=1 in RADDR → arvalid=0 and cmd_ready=1 immediately; no rsp_valid after release; next read of 0x00 returns correct data.
- Read of unmapped 0x08 → rsp_rdata=0x00000000, rsp_timeout=0.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: master FSM states, default bus widths and the register map.
package axi_lite_pkg;

  localparam int unsigned AXI_ADDRESS_WIDTH_DEF = 5;
  localparam int unsigned AXI_DATA_WIDTH_DEF    = 32;

  localparam logic [AXI_ADDRESS_WIDTH_DEF-1:0] REG1_ADDR = 5'h00;
  localparam logic [AXI_ADDRESS_WIDTH_DEF-1:0] REG2_ADDR = 5'h04;

  typedef enum logic [2:0] {
    StIdle,
    StWaddrData,
    StWresp,
    StRaddr,
    StRdata,
    StResp
  } mst_state_e;

endpackage

// File: rtl/axi_lite_master_if.sv
// Command/response port plus the AXI4-Lite bus (no BRESP/RRESP) of the single-outstanding master.
interface axi_lite_master_if
  import axi_lite_pkg::*;
#(
  parameter int unsigned AXI_ADDRESS_WIDTH = AXI_ADDRESS_WIDTH_DEF,
  parameter int unsigned AXI_DATA_WIDTH    = AXI_DATA_WIDTH_DEF
) ();

  logic                         cmd_valid;
  logic                         cmd_ready;
  logic                         cmd_write;
  logic [AXI_ADDRESS_WIDTH-1:0] cmd_addr;
  logic [AXI_DATA_WIDTH-1:0]    cmd_wdata;
  logic                         rsp_valid;
  logic                         rsp_ready;
  logic [AXI_DATA_WIDTH-1:0]    rsp_rdata;
  logic                         rsp_timeout;

  logic [AXI_ADDRESS_WIDTH-1:0] maxi_awaddr;
  logic                         maxi_awvalid;
  logic                         maxi_awready;
  logic [AXI_DATA_WIDTH-1:0]    maxi_wdata;
  logic                         maxi_wvalid;
  logic                         maxi_wready;
  logic                         maxi_bvalid;
  logic                         maxi_bready;
  logic [AXI_ADDRESS_WIDTH-1:0] maxi_araddr;
  logic                         maxi_arvalid;
  logic                         maxi_arready;
  logic [AXI_DATA_WIDTH-1:0]    maxi_rdata;
  logic                         maxi_rvalid;
  logic                         maxi_rready;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_timeout,
    output maxi_awaddr, maxi_awvalid, maxi_wdata, maxi_wvalid, maxi_bready,
    output maxi_araddr, maxi_arvalid, maxi_rready,
    input  maxi_awready, maxi_wready, maxi_bvalid, maxi_arready, maxi_rdata, maxi_rvalid
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_timeout,
    input  maxi_awaddr, maxi_awvalid, maxi_wdata, maxi_wvalid, maxi_bready,
    input  maxi_araddr, maxi_arvalid, maxi_rready,
    output maxi_awready, maxi_wready, maxi_bvalid, maxi_arready, maxi_rdata, maxi_rvalid
  );

endinterface

// File: rtl/axi_lite_timeout_cnt.sv
// Saturating per-state cycle counter; tc_o flags the cycle whose edge reaches TIMEOUT_CYCLES.
module axi_lite_timeout_cnt #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned Last = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != CntW'(TIMEOUT_CYCLES))) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  // Firing one count early makes the abort land on the edge where the count reaches the limit.
  assign tc_o = (TIMEOUT_CYCLES != 0) && en_i && (cnt_q == CntW'(Last));

endmodule

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite master: one command in, one AXI read or write out, one response back.
module axi_lite_master
  import axi_lite_pkg::*;
#(
  parameter int unsigned AXI_ADDRESS_WIDTH = AXI_ADDRESS_WIDTH_DEF,
  parameter int unsigned AXI_DATA_WIDTH    = AXI_DATA_WIDTH_DEF,
  parameter int unsigned TIMEOUT_CYCLES    = 255
) (
  input logic               aclk,
  input logic               aresetn,
  axi_lite_master_if.master bus_io
);

  mst_state_e                   state_q;
  logic [AXI_ADDRESS_WIDTH-1:0] addr_q;
  logic [AXI_DATA_WIDTH-1:0]    wdata_q, rsp_rdata_q;
  logic awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q, rsp_valid_q, rsp_timeout_q;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, wr_done;
  logic step_done, leave, axi_busy, tmo_tc;

  assign aw_hs   = awvalid_q & bus_io.maxi_awready;
  assign w_hs    = wvalid_q & bus_io.maxi_wready;
  assign b_hs    = bready_q & bus_io.maxi_bvalid;
  assign ar_hs   = arvalid_q & bus_io.maxi_arready;
  assign r_hs    = rready_q & bus_io.maxi_rvalid;
  // A channel whose valid already dropped has finished its handshake earlier.
  assign wr_done = (~awvalid_q | aw_hs) & (~wvalid_q | w_hs);

  always_comb begin
    step_done = 1'b0;
    axi_busy  = 1'b0;
    unique case (state_q)
      StIdle:      step_done = bus_io.cmd_valid;
      StWaddrData: begin step_done = wr_done; axi_busy = 1'b1; end
      StWresp:     begin step_done = b_hs;    axi_busy = 1'b1; end
      StRaddr:     begin step_done = ar_hs;   axi_busy = 1'b1; end
      StRdata:     begin step_done = r_hs;    axi_busy = 1'b1; end
      StResp:      step_done = bus_io.rsp_ready;
      default:     step_done = 1'b0;
    endcase
    leave = step_done | tmo_tc;
  end

  axi_lite_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk_i (aclk),
    .rst_ni(aresetn),
    .clr_i (leave),
    .en_i  (axi_busy),
    .tc_o  (tmo_tc)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q       <= StIdle;
      addr_q        <= '0;
      wdata_q       <= '0;
      rsp_rdata_q   <= '0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else if (tmo_tc && !step_done) begin
      // Handshake on the terminal cycle takes precedence, so abort only when nothing completed.
      state_q       <= StResp;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      rsp_valid_q   <= 1'b1;
      rsp_timeout_q <= 1'b1;
      rsp_rdata_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus_io.cmd_valid) begin
            addr_q  <= bus_io.cmd_addr;
            wdata_q <= bus_io.cmd_wdata;
            if (bus_io.cmd_write) begin
              state_q   <= StWaddrData;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
            end else begin
              state_q   <= StRaddr;
              arvalid_q <= 1'b1;
            end
          end
        end
        StWaddrData: begin
          if (aw_hs) awvalid_q <= 1'b0;
          if (w_hs)  wvalid_q  <= 1'b0;
          if (wr_done) begin
            state_q  <= StWresp;
            bready_q <= 1'b1;
          end
        end
        StWresp: begin
          if (b_hs) begin
            state_q     <= StResp;
            bready_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= '0;
          end
        end
        StRaddr: begin
          if (ar_hs) begin
            state_q   <= StRdata;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
          end
        end
        StRdata: begin
          if (r_hs) begin
            state_q     <= StResp;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= bus_io.maxi_rdata;
          end
        end
        StResp: begin
          if (bus_io.rsp_ready) begin
            state_q       <= StIdle;
            rsp_valid_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus_io.cmd_ready    = (state_q == StIdle);
  assign bus_io.rsp_valid    = rsp_valid_q;
  assign bus_io.rsp_rdata    = rsp_rdata_q;
  assign bus_io.rsp_timeout  = rsp_timeout_q;
  assign bus_io.maxi_awaddr  = addr_q;
  assign bus_io.maxi_awvalid = awvalid_q;
  assign bus_io.maxi_wdata   = wdata_q;
  assign bus_io.maxi_wvalid  = wvalid_q;
  assign bus_io.maxi_bready  = bready_q;
  assign bus_io.maxi_araddr  = addr_q;
  assign bus_io.maxi_arvalid = arvalid_q;
  assign bus_io.maxi_rready  = rready_q;

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed bench for axi_lite_master against a behavioural reg1/reg2 slave with tunable stalls.
module tb_axi_lite_master;
  import axi_lite_pkg::*;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  axi_lite_master_if #(.AXI_ADDRESS_WIDTH(5), .AXI_DATA_WIDTH(32)) bus ();

  axi_lite_master #(
    .AXI_ADDRESS_WIDTH(5),
    .AXI_DATA_WIDTH   (32),
    .TIMEOUT_CYCLES   (16)
  ) dut (
    .aclk   (aclk),
    .aresetn(aresetn),
    .bus_io (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Slave model: readiness after a programmable number of valid cycles.
  int unsigned aw_delay = 0, w_delay = 0, ar_delay = 0;
  logic        b_never = 1'b0;
  int unsigned aw_cnt, w_cnt, ar_cnt;
  logic [31:0] reg1 = 32'h0, reg2 = 32'h0;
  logic [4:0]  wa;
  logic [31:0] wd, s_rdata;
  logic        got_aw, got_w, s_bvalid, s_rvalid;
  logic        aw_hs, w_hs, b_hs, ar_hs, r_hs, aw_now, w_now;
  logic [4:0]  wa_now;
  logic [31:0] wd_now;

  assign bus.maxi_awready = (aw_cnt >= aw_delay);
  assign bus.maxi_wready  = (w_cnt >= w_delay);
  assign bus.maxi_arready = (ar_cnt >= ar_delay);
  assign bus.maxi_bvalid  = s_bvalid;
  assign bus.maxi_rvalid  = s_rvalid;
  assign bus.maxi_rdata   = s_rdata;

  assign aw_hs  = bus.maxi_awvalid & bus.maxi_awready;
  assign w_hs   = bus.maxi_wvalid & bus.maxi_wready;
  assign b_hs   = bus.maxi_bvalid & bus.maxi_bready;
  assign ar_hs  = bus.maxi_arvalid & bus.maxi_arready;
  assign r_hs   = bus.maxi_rvalid & bus.maxi_rready;
  assign aw_now = got_aw | aw_hs;
  assign w_now  = got_w | w_hs;
  assign wa_now = aw_hs ? bus.maxi_awaddr : wa;
  assign wd_now = w_hs ? bus.maxi_wdata : wd;

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
      got_aw <= 1'b0; got_w <= 1'b0; s_bvalid <= 1'b0; s_rvalid <= 1'b0;
      s_rdata <= 32'h0; wa <= 5'h0; wd <= 32'h0;
    end else begin
      aw_cnt <= (bus.maxi_awvalid && !aw_hs) ? aw_cnt + 1 : 0;
      w_cnt  <= (bus.maxi_wvalid && !w_hs) ? w_cnt + 1 : 0;
      ar_cnt <= (bus.maxi_arvalid && !ar_hs) ? ar_cnt + 1 : 0;
      if (aw_hs) wa <= bus.maxi_awaddr;
      if (w_hs)  wd <= bus.maxi_wdata;
      if (b_hs)  s_bvalid <= 1'b0;
      if (aw_now && w_now) begin
        got_aw <= 1'b0;
        got_w  <= 1'b0;
        if (!b_never) s_bvalid <= 1'b1;
      end else begin
        got_aw <= aw_now;
        got_w  <= w_now;
      end
      if (ar_hs) begin
        s_rvalid <= 1'b1;
        s_rdata  <= (bus.maxi_araddr == REG1_ADDR) ? reg1 :
                    (bus.maxi_araddr == REG2_ADDR) ? reg2 : 32'h0;
      end else if (r_hs) begin
        s_rvalid <= 1'b0;
      end
    end
  end

  always @(posedge aclk) begin
    if (aresetn && aw_now && w_now) begin
      if (wa_now == REG1_ADDR)      reg1 <= wd_now;
      else if (wa_now == REG2_ADDR) reg2 <= wd_now;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic wr, input logic [4:0] addr, input logic [31:0] data);
    @(negedge aclk);
    check("cmd_ready_before_send", {31'h0, bus.cmd_ready}, 32'h1);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = data;
    @(posedge aclk);
    #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output logic [31:0] data, output logic tmo, output int cyc);
    cyc = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge aclk);
      if (bus.rsp_valid) begin
        cyc = k;
        break;
      end
    end
    if (cyc == 0) check("rsp_wait_bound", {31'h0, bus.rsp_valid}, 32'h1);
    data = bus.rsp_rdata;
    tmo  = bus.rsp_timeout;
    bus.rsp_ready = 1'b1;
    @(posedge aclk);
    #1 bus.rsp_ready = 1'b0;
  endtask

  logic [31:0] rd;
  logic        to;
  int          cyc;
  int          extra;

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 5'h0;
    bus.cmd_wdata = 32'h0;
    bus.rsp_ready = 1'b0;

    // Reset values
    #23;
    check("rst_cmd_ready", {31'h0, bus.cmd_ready}, 32'h1);
    check("rst_valids", {27'h0, bus.maxi_awvalid, bus.maxi_wvalid, bus.maxi_arvalid,
                         bus.maxi_bready, bus.maxi_rready}, 32'h0);
    check("rst_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
    check("rst_rsp_timeout", {31'h0, bus.rsp_timeout}, 32'h0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    check("rst_addr", {27'h0, bus.maxi_awaddr}, 32'h0);
    @(negedge aclk);
    aresetn = 1'b1;

    // Write reg1 then read it back, zero-wait slave
    send(1'b1, REG1_ADDR, 32'hDEADBEEF);
    wait_rsp(rd, to, cyc);
    check("wr1_timeout", {31'h0, to}, 32'h0);
    check("wr1_rdata", rd, 32'h0);
    check("wr1_latency", cyc, 32'd3);
    check("wr1_slave_reg1", reg1, 32'hDEADBEEF);
    send(1'b0, REG1_ADDR, 32'h0);
    wait_rsp(rd, to, cyc);
    check("rd1_rdata", rd, 32'hDEADBEEF);
    check("rd1_timeout", {31'h0, to}, 32'h0);
    check("rd1_latency", cyc, 32'd3);

    // W channel accepted 3 cycles before AW
    aw_delay = 3;
    send(1'b1, REG2_ADDR, 32'h12345678);
    @(negedge aclk);
    check("wr2_both_valid", {30'h0, bus.maxi_awvalid, bus.maxi_wvalid}, 32'h3);
    @(negedge aclk);
    check("wr2_w_dropped", {30'h0, bus.maxi_awvalid, bus.maxi_wvalid}, 32'h2);
    check("wr2_awaddr_stable", {27'h0, bus.maxi_awaddr}, 32'h4);
    wait_rsp(rd, to, cyc);
    check("wr2_latency", cyc, 32'd4);
    check("wr2_timeout", {31'h0, to}, 32'h0);
    extra = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      if (bus.rsp_valid) extra++;
    end
    check("wr2_single_rsp", extra, 32'd0);
    aw_delay = 0;
    send(1'b0, REG2_ADDR, 32'h0);
    wait_rsp(rd, to, cyc);
    check("rd2_rdata", rd, 32'h12345678);

    // B channel never answers: abort 16 cycles after WRESP entry
    b_never = 1'b1;
    send(1'b1, 5'h0C, 32'h0BADF00D);
    wait_rsp(rd, to, cyc);
    check("tmo_latency", cyc, 32'd18);
    check("tmo_flag", {31'h0, to}, 32'h1);
    check("tmo_rdata", rd, 32'h0);
    @(negedge aclk);
    check("tmo_bready_low", {31'h0, bus.maxi_bready}, 32'h0);
    check("tmo_flag_cleared", {31'h0, bus.rsp_timeout}, 32'h0);
    b_never = 1'b0;

    // Response back-pressure for 10 cycles with a pending command
    send(1'b0, REG2_ADDR, 32'h0);
    cyc = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge aclk);
      if (bus.rsp_valid) begin
        cyc = k;
        break;
      end
    end
    check("bp_rsp_seen", cyc, 32'd3);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = REG1_ADDR;
    for (int i = 0; i < 10; i++) begin
      @(negedge aclk);
      check("bp_rsp_valid_held", {31'h0, bus.rsp_valid}, 32'h1);
      check("bp_rdata_stable", bus.rsp_rdata, 32'h12345678);
      check("bp_cmd_ready_low", {31'h0, bus.cmd_ready}, 32'h0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge aclk);
    #1 bus.rsp_ready = 1'b0;
    @(negedge aclk);
    check("bp_idle_cmd_ready", {31'h0, bus.cmd_ready}, 32'h1);
    check("bp_rsp_released", {31'h0, bus.rsp_valid}, 32'h0);
    check("bp_not_yet_issued", {31'h0, bus.maxi_arvalid}, 32'h0);
    @(posedge aclk);
    #1 bus.cmd_valid = 1'b0;
    check("b2b_arvalid", {31'h0, bus.maxi_arvalid}, 32'h1);
    check("b2b_cmd_ready", {31'h0, bus.cmd_ready}, 32'h0);
    wait_rsp(rd, to, cyc);
    check("b2b_rdata", rd, 32'hDEADBEEF);
    check("b2b_latency", cyc, 32'd3);

    // Asynchronous reset while stalled in RADDR
    ar_delay = 5;
    send(1'b0, REG1_ADDR, 32'h0);
    @(negedge aclk);
    check("rst_mid_arvalid_before", {31'h0, bus.maxi_arvalid}, 32'h1);
    #2 aresetn = 1'b0;
    #1;
    check("rst_mid_arvalid", {31'h0, bus.maxi_arvalid}, 32'h0);
    check("rst_mid_cmd_ready", {31'h0, bus.cmd_ready}, 32'h1);
    @(negedge aclk);
    aresetn  = 1'b1;
    ar_delay = 0;
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge aclk);
      if (bus.rsp_valid) extra++;
    end
    check("rst_mid_no_rsp", extra, 32'd0);
    send(1'b0, REG1_ADDR, 32'h0);
    wait_rsp(rd, to, cyc);
    check("rst_mid_reread", rd, 32'hDEADBEEF);
    check("rst_mid_reread_tmo", {31'h0, to}, 32'h0);

    // Unmapped read
    send(1'b0, 5'h08, 32'h0);
    wait_rsp(rd, to, cyc);
    check("unmapped_rdata", rd, 32'h0);
    check("unmapped_timeout", {31'h0, to}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
